// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one synchronous 8 KB screen RAM between video fetches and CPU
//   accesses. Video owns the RAM while VID_LO <= vid_phase <= VID_HI. The CPU
//   gets the RAM in any other cycle through a req/ack handshake.
//
// Parameters
//   VID_LO, VID_HI : first and last video-owned vid_phase values (inclusive)
// Ports
//   clk_pix, nreset          : pixel clock, async active-low reset
//   vid_phase, vid_address   : video horizontal phase and fetch address
//   vid_data                 : video read data (ram_rdata passed straight through)
//   cpu_req/we/address/wdata : CPU request; level req, held until cpu_ack
//   cpu_rdata                : registered CPU read data
//   cpu_ack                  : one-cycle completion pulse
//   cpu_nwait                : active-low wait for CPU WAIT insertion
//   ram_address/wdata/we     : RAM command
//   ram_rdata                : RAM read data, one cycle after the address edge
module vram_arbiter #(
  parameter int unsigned VID_LO = 11,
  parameter int unsigned VID_HI = 14
) (
  input  logic        clk_pix,
  input  logic        nreset,
  input  logic [3:0]  vid_phase,
  input  logic [12:0] vid_address,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_nwait,
  output logic [12:0] ram_address,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  localparam logic [3:0] VID_LO_P = 4'(VID_LO);
  localparam logic [3:0] VID_HI_P = 4'(VID_HI);

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    CAPTURE,
    ACK,
    RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        in_window;

  assign in_window = (vid_phase >= VID_LO_P) && (vid_phase <= VID_HI_P);
  assign vid_data  = ram_rdata;
  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk_pix or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ram_address = addr_q;
    ram_wdata   = wdata_q;
    ram_we      = 1'b0;
    cpu_ack     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_address;
          wdata_d = cpu_wdata;
          state_d = PEND;
        end
      end
      PEND: begin
        // Issue only outside the video window; otherwise wait here.
        if (!in_window) begin
          ram_we  = we_q;
          state_d = we_q ? ACK : CAPTURE;
        end
      end
      CAPTURE: begin
        // Data returned for the address issued in PEND, even if this cycle
        // is already inside the window (RAM has one-cycle latency).
        rdata_d = ram_rdata;
        state_d = ACK;
      end
      ACK: begin
        cpu_ack = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!cpu_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Video always wins the RAM inside its window.
    if (in_window) begin
      ram_address = vid_address;
      ram_we      = 1'b0;
    end
  end

  always_comb begin
    cpu_nwait = 1'b1;
    if (cpu_req && ((state_q == IDLE) || (state_q == PEND) || (state_q == CAPTURE)))
      cpu_nwait = 1'b0;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed bench for vram_arbiter with a behavioural synchronous RAM
//   (one-cycle read latency, read-before-write). vid_phase advances by one
//   each clock inside tick(); after tick() the signals describe the cycle
//   whose phase is vid_phase.
module tb_vram_arbiter;

  logic        clk_pix = 1'b0;
  logic        nreset;
  logic [3:0]  vid_phase;
  logic [12:0] vid_address;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_nwait;
  logic [12:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = 8'h00;

  logic [7:0]  mem [0:8191];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          ack_cnt = 0;

  vram_arbiter #(.VID_LO(11), .VID_HI(14)) dut (
    .clk_pix     (clk_pix),
    .nreset      (nreset),
    .vid_phase   (vid_phase),
    .vid_address (vid_address),
    .vid_data    (vid_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .cpu_nwait   (cpu_nwait),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    if (ram_we) mem[ram_address] <= ram_wdata;
    ram_rdata <= mem[ram_address];
  end

  always @(negedge clk_pix) begin
    if (nreset === 1'b1) begin
      if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
      if (cpu_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk_pix);
    #1;
    vid_phase = vid_phase + 4'd1;
    #1;
  endtask

  task automatic goto_phase(input logic [3:0] p);
    for (int n = 0; n < 17 && vid_phase != p; n++) tick();
  endtask

  task automatic test_reset();
    nreset = 1'b0; vid_phase = 4'd0; vid_address = 13'h0123;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk_pix);
    #1;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", cpu_ack); end
    checks++;
    if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", cpu_rdata); end
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
    checks++;
    if (cpu_nwait !== 1'b1) begin errors++; $display("FAIL rst_nwait got %b want 1", cpu_nwait); end
    checks++;
    if (ram_address !== 13'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", ram_address); end
    checks++;
    if (ram_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %h want 00", ram_wdata); end
    checks++;
    nreset = 1'b1;
  endtask

  task automatic test_write_nostall();
    goto_phase(4'd3);
    cpu_we = 1'b1; cpu_address = 13'h1ABC; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    #1;
    if (cpu_nwait !== 1'b0) begin errors++; $display("FAIL wr_nwait_idle got %b want 0", cpu_nwait); end
    checks++;
    tick(); // phase 4
    if (ram_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", ram_we); end
    checks++;
    if (ram_address !== 13'h1ABC) begin errors++; $display("FAIL wr_addr got %h want 1abc", ram_address); end
    checks++;
    if (ram_wdata !== 8'h5A) begin errors++; $display("FAIL wr_wdata got %h want 5a", ram_wdata); end
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b want 0", cpu_ack); end
    checks++;
    tick(); // phase 5
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", cpu_ack); end
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_we_after got %b want 0", ram_we); end
    checks++;
    cpu_req = 1'b0;
    tick(); // phase 6
    if (cpu_nwait !== 1'b1) begin errors++; $display("FAIL wr_nwait_rel got %b want 1", cpu_nwait); end
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_one got %b want 0", cpu_ack); end
    checks++;
    tick();
    if (mem[13'h1ABC] !== 8'h5A) begin errors++; $display("FAIL wr_mem got %h want 5a", mem[13'h1ABC]); end
    checks++;
  endtask

  task automatic test_write_stall();
    goto_phase(4'd10);
    cpu_we = 1'b1; cpu_address = 13'h0200; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    tick(); // phase 11
    for (int p = 11; p <= 14; p++) begin
      if (ram_address !== 13'h0123 || ram_we !== 1'b0) begin
        errors++; $display("FAIL stall_win phase %0d got addr %h we %b want 0123 0", p, ram_address, ram_we);
      end
      checks++;
      if (cpu_nwait !== 1'b0 || cpu_ack !== 1'b0) begin
        errors++; $display("FAIL stall_wait phase %0d got nwait %b ack %b want 0 0", p, cpu_nwait, cpu_ack);
      end
      checks++;
      if (p >= 12 && vid_data !== 8'h3C) begin
        errors++; $display("FAIL stall_vid phase %0d got %h want 3c", p, vid_data);
      end
      if (p >= 12) checks++;
      tick();
    end
    // phase 15
    if (ram_we !== 1'b1 || ram_address !== 13'h0200) begin
      errors++; $display("FAIL stall_issue got we %b addr %h want 1 0200", ram_we, ram_address);
    end
    checks++;
    if (vid_data !== 8'h3C) begin errors++; $display("FAIL stall_vid15 got %h want 3c", vid_data); end
    checks++;
    tick(); // phase 0
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL stall_ack got %b want 1", cpu_ack); end
    checks++;
    cpu_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_collision();
    vid_address = 13'h0300;
    goto_phase(4'd9);
    cpu_we = 1'b1; cpu_address = 13'h0300; cpu_wdata = 8'h77; cpu_req = 1'b1;
    tick(); // phase 10
    if (ram_we !== 1'b1 || ram_address !== 13'h0300) begin
      errors++; $display("FAIL coll_issue got we %b addr %h want 1 0300", ram_we, ram_address);
    end
    checks++;
    tick(); // phase 11
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL coll_ack got %b want 1", cpu_ack); end
    checks++;
    cpu_req = 1'b0;
    tick(); // phase 12
    if (vid_data !== 8'h77) begin errors++; $display("FAIL coll_vid got %h want 77", vid_data); end
    checks++;
    vid_address = 13'h0123;
    tick();
  endtask

  task automatic test_read();
    goto_phase(4'd8);
    cpu_we = 1'b0; cpu_address = 13'h0040; cpu_wdata = 8'hEE; cpu_req = 1'b1;
    tick(); // phase 9
    if (ram_we !== 1'b0 || ram_address !== 13'h0040) begin
      errors++; $display("FAIL rd_issue got we %b addr %h want 0 0040", ram_we, ram_address);
    end
    checks++;
    tick(); // phase 10
    if (cpu_nwait !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL rd_capture got nwait %b ack %b want 0 0", cpu_nwait, cpu_ack);
    end
    checks++;
    tick(); // phase 11
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %b want 1", cpu_ack); end
    checks++;
    if (cpu_rdata !== 8'hC3) begin errors++; $display("FAIL rd_data got %h want c3", cpu_rdata); end
    checks++;
    cpu_req = 1'b0;
    tick(); // phase 12
    if (vid_data !== 8'h3C) begin errors++; $display("FAIL rd_vid got %h want 3c", vid_data); end
    checks++;
  endtask

  task automatic test_back_to_back();
    int w0, a0;
    bit seen;
    w0 = we_cnt; a0 = ack_cnt;
    goto_phase(4'd0);
    cpu_we = 1'b1; cpu_address = 13'h0600; cpu_wdata = 8'h42; cpu_req = 1'b1;
    tick(); tick(); // phase 2: ACK
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL held_ack got %b want 1", cpu_ack); end
    checks++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ack !== 1'b0 || cpu_nwait !== 1'b1 || ram_we !== 1'b0) begin
        errors++; $display("FAIL held_quiet cycle %0d got ack %b nwait %b we %b want 0 1 0", i, cpu_ack, cpu_nwait, ram_we);
      end
      checks++;
    end
    if (we_cnt - w0 != 1) begin errors++; $display("FAIL held_we_count got %0d want 1", we_cnt - w0); end
    checks++;
    if (ack_cnt - a0 != 1) begin errors++; $display("FAIL held_ack_count got %0d want 1", ack_cnt - a0); end
    checks++;
    if (cpu_rdata !== 8'hC3) begin errors++; $display("FAIL held_rdata_keep got %h want c3", cpu_rdata); end
    checks++;
    cpu_req = 1'b0;
    tick();
    goto_phase(4'd1);
    cpu_we = 1'b0; cpu_address = 13'h0600; cpu_req = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      tick();
      if (cpu_ack === 1'b1) seen = 1'b1;
    end
    if (!seen) begin errors++; $display("FAIL again_ack got none want pulse within 10 cycles"); end
    checks++;
    if (cpu_rdata !== 8'h42) begin errors++; $display("FAIL again_rdata got %h want 42", cpu_rdata); end
    checks++;
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int w0, a0;
    w0 = we_cnt; a0 = ack_cnt;
    goto_phase(4'd10);
    cpu_we = 1'b1; cpu_address = 13'h0700; cpu_wdata = 8'h99; cpu_req = 1'b1;
    tick(); tick(); tick(); // phase 13, PEND in window
    nreset = 1'b0;
    #1;
    if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL abort_out got ack %b we %b want 0 0", cpu_ack, ram_we);
    end
    checks++;
    if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata got %h want 00", cpu_rdata); end
    checks++;
    if (cpu_nwait !== 1'b0) begin errors++; $display("FAIL abort_idle_nwait got %b want 0", cpu_nwait); end
    checks++;
    cpu_address = 13'h0710; cpu_wdata = 8'h12;
    nreset = 1'b1;
    tick(); // phase 14: PEND, window
    if (ram_we !== 1'b0) begin errors++; $display("FAIL abort_win_we got %b want 0", ram_we); end
    checks++;
    tick(); // phase 15: issue
    if (ram_we !== 1'b1 || ram_address !== 13'h0710 || ram_wdata !== 8'h12) begin
      errors++; $display("FAIL post_rst_issue got we %b addr %h data %h want 1 0710 12", ram_we, ram_address, ram_wdata);
    end
    checks++;
    tick(); // phase 0
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL post_rst_ack got %b want 1", cpu_ack); end
    checks++;
    cpu_req = 1'b0;
    tick(); tick();
    if (we_cnt - w0 != 1) begin errors++; $display("FAIL abort_we_count got %0d want 1", we_cnt - w0); end
    checks++;
    if (ack_cnt - a0 != 1) begin errors++; $display("FAIL abort_ack_count got %0d want 1", ack_cnt - a0); end
    checks++;
    if (mem[13'h0700] !== 8'h00) begin errors++; $display("FAIL abort_mem got %h want 00", mem[13'h0700]); end
    checks++;
    if (mem[13'h0710] !== 8'h12) begin errors++; $display("FAIL post_rst_mem got %h want 12", mem[13'h0710]); end
    checks++;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0040] = 8'hC3;
    mem[13'h0123] = 8'h3C;
    test_reset();
    test_write_nostall();
    test_write_stall();
    test_collision();
    test_read();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Purpose: sits upstream of the video fetch stage. Time-multiplexes one synchronous 8 KB screen RAM between video fetches (fixed priority slots) and CPU accesses (req/ack handshake).

Interface
REQ-001 SHALL have parameter VID_LO, default 11, meaning the first video-owned vid_phase value.
REQ-002 SHALL have parameter VID_HI, default 14, meaning the last video-owned vid_phase value (window is inclusive).
REQ-003 clk_pix  in  1  pixel clock; all state changes on rising edge.
REQ-004 nreset  in  1  reset, asynchronous, active-low.
REQ-005 vid_phase  in  4  video horizontal counter bits [3:0].
REQ-006 vid_address  in  13  video fetch address.
REQ-007 vid_data  out  8  video read data.
REQ-008 cpu_req  in  1  CPU access request, level, held until cpu_ack is seen.
REQ-009 cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-010 cpu_address  in  13  CPU address.
REQ-011 cpu_wdata  in  8  CPU write data.
REQ-012 cpu_rdata  out  8  CPU read data, registered.
REQ-013 cpu_ack  out  1  one-cycle completion pulse.
REQ-014 cpu_nwait  out  1  active-low wait, for CPU WAIT insertion.
REQ-015 ram_address  out  13  RAM address.
REQ-016 ram_wdata  out  8  RAM write data.
REQ-017 ram_we  out  1  RAM write enable.
REQ-018 ram_rdata  in  8  RAM read data; one-cycle latency from the address edge.

Function
REQ-019 Video window SHALL be VID_LO <= vid_phase <= VID_HI. In the window: ram_address = vid_address, ram_we = 0, regardless of CPU state.
REQ-020 vid_data SHALL be ram_rdata combinationally (no added latency).
REQ-021 CPU FSM states SHALL be IDLE, PEND, CAPTURE, ACK and RELEASE.
REQ-022 IDLE: on cpu_req = 1, latch cpu_we, cpu_address and cpu_wdata into internal registers, then go to PEND; else stay.
REQ-023 PEND outside the window: drive ram_address = latched address, ram_wdata = latched data, ram_we = latched we.
REQ-024 From PEND, a write SHALL go to ACK and a read SHALL go to CAPTURE.
REQ-025 PEND inside the window: no CPU drive; stay in PEND.
REQ-026 CAPTURE: cpu_rdata <= ram_rdata at the end of the cycle; go to ACK. The result is valid even if CAPTURE falls in the window.
REQ-027 ACK: cpu_ack = 1 for exactly this cycle; go to RELEASE.
REQ-028 RELEASE: stay while cpu_req = 1; go to IDLE when cpu_req = 0. No second access is issued on a held request.
REQ-029 Outside PEND-issue and the window, ram_address SHALL be the latched CPU address and ram_we SHALL be 0.
REQ-030 ram_we SHALL be 1 for exactly one cycle per CPU write, and never inside the window.
REQ-031 cpu_nwait SHALL be 0 when (cpu_req = 1 and state is IDLE, PEND or CAPTURE); 1 otherwise.
REQ-032 Latency from the request-sampling edge:
- write ack, no stall: 2 cycles.
- read ack, no stall: 3 cycles.
- each window cycle in PEND adds 1 cycle.
- maximum stall is VID_HI-VID_LO+1 = 4 cycles.
REQ-033 Collision: a CPU write issued at phase VID_LO-1 SHALL be visible to the video read at VID_LO.
REQ-034 cpu_rdata SHALL hold its value until the next CAPTURE.
REQ-035 vid_phase wraps 15 -> 0 with no special handling.

Reset
REQ-036 nreset = 0 SHALL asynchronously force:
- state IDLE.
- cpu_ack 0, cpu_rdata 0x00.
- latched we/address/data 0.
- ram_we 0.
REQ-037 Reset asserted in PEND or CAPTURE SHALL abort the access: no RAM write occurs and no ack is produced.
REQ-038 After nreset deasserts, the first cpu_req SHALL be sampled on the first rising edge.

Verification
REQ-039 Write, req sampled at phase 3, addr 0x1ABC, data 0x5A -> phase 4: ram_we = 1, ram_address = 0x1ABC, ram_wdata = 0x5A; phase 5: cpu_ack = 1; phase 6: cpu_nwait = 1.
REQ-040 Write, req sampled at phase 10 -> PEND during phases 11-14 with ram_we = 0 and ram_address = vid_address; issue at phase 15; cpu_ack at phase 0.
REQ-041 Read of 0x0040 (RAM holds 0xC3), req sampled at phase 8 -> issue at phase 9, CAPTURE at phase 10, cpu_rdata = 0xC3 and cpu_ack = 1 at phase 11; video data at phase 12 unaffected.
REQ-042 vid_address = 0x0123 with a CPU request pending -> ram_address = 0x0123 and ram_we = 0 for phases 11-14; vid_data equals RAM[0x0123] at phases 12-15.
REQ-043 cpu_req held 10 cycles after ack -> exactly one RAM access and one ack pulse; a new request after req low is serviced normally.
REQ-044 nreset pulsed while in PEND with a write pending -> no ram_we pulse, no cpu_ack, state IDLE, cpu_rdata = 0x00.
